mem_fill_arbiter: RTL

- Single-owner scheduler for the unified main-memory port.
- Shares the port between I-cache line fills, D-cache line fills and D-cache write-through stores.
- Sequences each 8-word line fill: issue addresses, count returning words, drive data/tag write enables to the owning cache.
- Sits between both caches' miss detection and the 4-cycle pipelined memory; produces the pipeline stall signals.

---
 rtl/mem_fill_arbiter_if.sv | 47 ++++
 rtl/mem_fill_arbiter.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_fill_arbiter_if.sv
// Bundle between the fill/store scheduler, the two caches' miss logic and the
// pipelined main-memory port. "master" is the scheduler, "slave" is everything around it.
interface mem_fill_arbiter_if;
  // Requests from the caches
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_store;
  logic [15:0] store_addr;
  logic [15:0] store_data;

  // Main-memory port
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;

  // Cache array write strobes
  logic        icache_data_wen;
  logic        icache_tag_wen;
  logic        dcache_data_wen;
  logic        dcache_tag_wen;
  logic [2:0]  fill_word_offset;
  logic        store_done;

  // Pipeline stalls
  logic        i_stall;
  logic        d_stall;

  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_store, store_addr, store_data, mem_data_valid,
    output mem_enable, mem_wr, mem_addr, mem_data_in,
           icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen,
           fill_word_offset, store_done, i_stall, d_stall
  );

  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr,
           dcache_store, store_addr, store_data, mem_data_valid,
    input  mem_enable, mem_wr, mem_addr, mem_data_in,
           icache_data_wen, icache_tag_wen, dcache_data_wen, dcache_tag_wen,
           fill_word_offset, store_done, i_stall, d_stall
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// Single owner of the main-memory port: schedules write-through stores and
// 8-word I/D line fills, drives cache array write strobes and pipeline stalls.
module mem_fill_arbiter #(
  parameter int unsigned WORDS_PER_LINE = 8,
  parameter int unsigned MEM_LATENCY    = 4
) (
  input logic               clk,
  input logic               rst,
  mem_fill_arbiter_if.master bus
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W = OFF_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] LINE_WORDS = CNT_W'(WORDS_PER_LINE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_TAG,
    S_STORE
  } state_t;

  state_t state, state_nxt;

  logic                 owner;       // 0 = I-cache, 1 = D-cache
  logic                 last_fill;   // round-robin history, same encoding
  logic [15-OFF_W-1:0]  line_base;
  logic [CNT_W-1:0]     issue_cnt;
  logic [CNT_W-1:0]     ret_cnt;
  logic [15:0]          st_addr;
  logic [15:0]          st_data;

  logic grant_store;
  logic grant_miss;
  logic grant_owner;
  logic rd_issue;
  logic rd_return;

  logic i_data_wen, i_tag_wen, d_data_wen, d_tag_wen;
  logic st_done;

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and output decode
  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt            = state;
    grant_store          = 1'b0;
    grant_miss           = 1'b0;
    grant_owner          = 1'b0;
    rd_issue             = 1'b0;
    rd_return            = 1'b0;
    i_data_wen           = 1'b0;
    i_tag_wen            = 1'b0;
    d_data_wen           = 1'b0;
    d_tag_wen            = 1'b0;
    st_done              = 1'b0;
    bus.mem_enable       = 1'b0;
    bus.mem_wr           = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_data_in      = '0;
    bus.fill_word_offset = '0;

    unique case (state)
      S_IDLE: begin
        // Stores win outright; two misses alternate away from the last fill
        if (bus.dcache_store) begin
          grant_store = 1'b1;
          state_nxt   = S_STORE;
        end else if (bus.icache_miss || bus.dcache_miss) begin
          grant_miss  = 1'b1;
          grant_owner = (bus.icache_miss && bus.dcache_miss) ? ~last_fill : bus.dcache_miss;
          state_nxt   = S_FILL;
        end
      end

      S_STORE: begin
        bus.mem_enable  = 1'b1;
        bus.mem_wr      = 1'b1;
        bus.mem_addr    = st_addr;
        bus.mem_data_in = st_data;
        st_done         = 1'b1;
        state_nxt       = S_IDLE;
      end

      S_FILL: begin
        if (issue_cnt < LINE_WORDS) begin
          rd_issue       = 1'b1;
          bus.mem_enable = 1'b1;
          bus.mem_addr   = {line_base, issue_cnt[OFF_W-1:0], 1'b0};
        end
        if (bus.mem_data_valid && (ret_cnt < LINE_WORDS)) begin
          rd_return            = 1'b1;
          bus.fill_word_offset = ret_cnt[OFF_W-1:0];
          if (owner) d_data_wen = 1'b1;
          else       i_data_wen = 1'b1;
          if (ret_cnt == LAST_WORD) state_nxt = S_TAG;
        end
      end

      S_TAG: begin
        if (owner) d_tag_wen = 1'b1;
        else       i_tag_wen = 1'b1;
        state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // Fill/store context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner     <= 1'b0;
      last_fill <= 1'b0;
      line_base <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      st_addr   <= '0;
      st_data   <= '0;
    end else begin
      if (grant_miss) begin
        owner     <= grant_owner;
        line_base <= grant_owner ? bus.dcache_miss_addr[15:OFF_W+1]
                                 : bus.icache_miss_addr[15:OFF_W+1];
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        if (rd_issue)  issue_cnt <= issue_cnt + 1'b1;
        if (rd_return) ret_cnt   <= ret_cnt + 1'b1;
      end
      if (grant_store) begin
        st_addr <= bus.store_addr;
        st_data <= bus.store_data;
      end
      if (state == S_TAG) last_fill <= owner;
    end
  end

  assign bus.icache_data_wen = i_data_wen;
  assign bus.icache_tag_wen  = i_tag_wen;
  assign bus.dcache_data_wen = d_data_wen;
  assign bus.dcache_tag_wen  = d_tag_wen;
  assign bus.store_done      = st_done;

  // Stalls are forced low while reset is held so every output reads 0 in reset
  assign bus.i_stall = ~rst & bus.icache_miss & ~i_tag_wen;
  assign bus.d_stall = ~rst & ((bus.dcache_miss & ~d_tag_wen) | (bus.dcache_store & ~st_done));

  // Memory contract: a counted return always matches a read issued MEM_LATENCY cycles earlier
  assert property (@(posedge clk) disable iff (rst)
    rd_return |-> $past(rd_issue, MEM_LATENCY));

endmodule
